cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Fetch/decode/execute/writeback controller for the 16-bit accumulator CPU. It fetches instruction words from program memory over a req/ack handshake and holds each one in an instruction register that feeds `instruction_decoder`. It issues one-cycle execute and writeback strobes that gate the decoder's ALU, accumulator and register-file enables. It owns the program counter, a retired-instruction counter, halt handling and a fetch-timeout error.

## Interface
- `PC_W`, default 8: program counter and `imem_addr` width.
- `ACK_TIMEOUT`, default 15: consecutive FETCH cycles without `imem_ack` that raise an error.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; leaves IDLE or HALT.
- `halt_req` in 1: halt after the current instruction retires.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_W: fetch address; equals `pc` while `imem_req` is high.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 16: instruction word, sampled when `imem_req && imem_ack`.
- `ir` out 16: instruction register, to the decoder's `instruction` input.
- `exec_en` out 1: one-cycle strobe; ANDed with the decoder's `ALU_ce`/`A_ce`.
- `wb_en` out 1: one-cycle strobe; ANDed with the decoder's `RF_we`.
- `pc` out PC_W: address of the next fetch.
- `instr_count` out 16: retired instructions.
- `busy` out 1: high in FETCH, DECODE, EXECUTE and WRITEBACK.
- `halted` out 1: high in HALT.
- `err` out 1: sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset values: state IDLE; `pc`=0; `ir`=16'h0000; `instr_count`=0; `err`=0. The halt latch and timeout counter clear. Every strobe and status output is 0.
- `rst` overrides everything, including mid-fetch. `imem_req` is low the cycle after the reset edge. An in-flight ack is ignored.
- IDLE: on `start`, go to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`. An ack may arrive in the first FETCH cycle.
  - On ack: `ir`<=`imem_rdata`, `pc`<=`pc`+1 (wraps 2^PC_W-1 to 0), timeout counter clears, go to DECODE.
  - Without ack: timeout counter increments.
  - When the counter reaches `ACK_TIMEOUT`: `err`<=1, go to HALT, `pc` unchanged.
- DECODE: one cycle; `ir` stable for the combinational decoder. No strobes.
- EXECUTE: `exec_en`=1 for exactly one cycle.
- WRITEBACK:
  - `wb_en`=1 for exactly one cycle.
  - `instr_count` increments and saturates at 16'hFFFF.
  - If the halt latch is set, go to HALT and clear the latch; otherwise go to FETCH.
- Halt latch: set by `halt_req` high in any cycle from DECODE through WRITEBACK inclusive. In FETCH it is ignored, so a fetched instruction always completes.
- `halt_req` in IDLE or HALT has no effect.
- HALT:
  - All strobes 0; `ir` and `pc` hold.
  - `start` clears `err` and goes to FETCH, resuming at the current `pc`.
- `start` in any busy state is ignored.
- `ir` changes only on an accepted fetch or reset.

## Timing
- Registered outputs: state-derived strobes, `imem_req`, `busy` and `halted` are decoded from the registered state (Moore), with no combinational path from inputs.
- Instruction latency with ack in the first FETCH cycle: 4 cycles per instruction (F, D, E, W). Each extra ack wait adds 1 cycle.
- `start` sampled at edge N in IDLE: `imem_req` is high in cycle N+1.
- Ack at edge N: `ir` and `pc` update at N; `exec_en` is high in cycle N+2 and `wb_en` in cycle N+3.
- Timeout: `err` is set and the state enters HALT exactly `ACK_TIMEOUT` cycles after FETCH entry when no ack arrives. An ack on the last counted cycle is accepted; no error.
- `halt_req` and ack are unrelated events. Both arriving in the same FETCH cycle: the fetch is accepted and `halt_req` is ignored.

## Test plan
- Reset, then `start` pulse; memory acks immediately with words 16'h1000, 16'h2001, 16'h3002 at addresses 0..2:
  - `ir` takes each value in turn.
  - `exec_en` and `wb_en` each pulse once per 4 cycles.
  - `pc` reads 1, 2, 3; `instr_count`=3 after the third WRITEBACK.
- Ack delayed 3 cycles at address 5: `imem_req` stays high for 4 cycles with `imem_addr`=5; the instruction takes 7 cycles; no `err`.
- No ack with `ACK_TIMEOUT`=15: `err`=1 and `halted`=1 exactly 15 cycles after FETCH entry; `pc` unchanged. A following `start` clears `err` and re-fetches the same address.
- `halt_req` pulsed during EXECUTE of the instruction at `pc`=7: WRITEBACK completes, state goes to HALT, `pc`=8. `start` resumes with `imem_addr`=8. A `halt_req` pulsed only during FETCH does not halt.
- `PC_W`=8, `pc`=8'hFF, ack: `pc` wraps to 8'h00 and the next fetch address is 0.
- `rst` asserted during EXECUTE:
  - The next cycle shows IDLE, `pc`=0, `ir`=0 and `instr_count`=0, with no `wb_en` pulse.
  - A late `imem_ack` after reset has no effect.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-fetch bus plus sequencer control/status.
// master is the sequencer side, slave the memory/host side.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            halt_req;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [15:0]     ir;
  logic            exec_en;
  logic            wb_en;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr_count;
  logic            busy;
  logic            halted;
  logic            err;

  modport master (
    input  start, halt_req, imem_ack, imem_rdata,
    output imem_req, imem_addr, ir, exec_en, wb_en,
    output pc, instr_count, busy, halted, err
  );

  modport slave (
    output start, halt_req, imem_ack, imem_rdata,
    input  imem_req, imem_addr, ir, exec_en, wb_en,
    input  pc, instr_count, busy, halted, err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute/writeback controller for the
// 16-bit accumulator CPU; owns pc, ir, retire count, halt and timeout.
module cpu_sequencer #(
  parameter int PC_W        = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            halt_q, halt_d;
  logic [TW-1:0]   to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    halt_d  = halt_q;
    to_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        // an ack on the last counted cycle still wins over the timeout
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = DECODE;
        end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DECODE: begin
        halt_d  = halt_q | bus.halt_req;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        halt_d  = halt_q | bus.halt_req;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        if (halt_q || bus.halt_req) begin
          halt_d  = 1'b0;
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      HALT: begin
        if (bus.start) begin
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.ir          = ir_q;
  assign bus.exec_en     = (state_q == EXECUTE);
  assign bus.wb_en       = (state_q == WRITEBACK);
  assign bus.pc          = pc_q;
  assign bus.instr_count = cnt_q;
  assign bus.busy        = (state_q == FETCH) || (state_q == DECODE) ||
                           (state_q == EXECUTE) || (state_q == WRITEBACK);
  assign bus.halted      = (state_q == HALT);
  assign bus.err         = err_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized bench with a transaction-level model
// of pc, ir, retire count and halt behaviour.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(8)) bus ();

  cpu_sequencer #(.PC_W(8), .ACK_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [256];
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  int          m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.halt_req = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    m_pc = '0;
    m_ir = '0;
    m_cnt = 0;
  endtask

  // Entered at a negedge with FETCH visible; leaves at the negedge
  // after WRITEBACK. hph: 0 none, 1 fetch, 2 decode, 3 exec, 4 wb.
  task automatic run_instr(input int wt, input int hph);
    logic [15:0] w;
    logic        hlt;
    w = mem[m_pc];
    hlt = (hph >= 2);
    for (int k = 0; k <= wt; k++) begin
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc ||
          bus.exec_en !== 1'b0 || bus.wb_en !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch k=%0d req=%b addr=%h exp req=1 addr=%h",
                 k, bus.imem_req, bus.imem_addr, m_pc);
      end
      bus.imem_ack = (k == wt);
      bus.imem_rdata = (k == wt) ? w : 16'($urandom);
      bus.halt_req = (hph == 1) && (k == wt);
      bus.start = 1'($urandom);
      @(negedge clk);
    end
    m_ir = w;
    m_pc = m_pc + 8'd1;
    bus.imem_ack = 1'b0;
    bus.halt_req = (hph == 2);
    n_chk++;
    if (bus.ir !== m_ir || bus.pc !== m_pc || bus.imem_req !== 1'b0 ||
        bus.exec_en !== 1'b0 || bus.wb_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL decode ir=%h pc=%h req=%b ex=%b wb=%b exp ir=%h pc=%h",
               bus.ir, bus.pc, bus.imem_req, bus.exec_en, bus.wb_en,
               m_ir, m_pc);
    end
    @(negedge clk);
    bus.halt_req = (hph == 3);
    n_chk++;
    if (bus.exec_en !== 1'b1 || bus.wb_en !== 1'b0 || bus.ir !== m_ir) begin
      n_fail++;
      $display("FAIL execute ex=%b wb=%b ir=%h exp ex=1 wb=0 ir=%h",
               bus.exec_en, bus.wb_en, bus.ir, m_ir);
    end
    @(negedge clk);
    bus.halt_req = (hph == 4);
    n_chk++;
    if (bus.wb_en !== 1'b1 || bus.exec_en !== 1'b0) begin
      n_fail++;
      $display("FAIL writeback wb=%b ex=%b exp wb=1 ex=0",
               bus.wb_en, bus.exec_en);
    end
    @(negedge clk);
    bus.halt_req = 1'b0;
    bus.start = 1'b0;
    m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
    n_chk++;
    if (bus.instr_count !== 16'(m_cnt) || bus.halted !== hlt ||
        bus.imem_req !== !hlt || bus.err !== 1'b0 || bus.pc !== m_pc) begin
      n_fail++;
      $display("FAIL retire cnt=%0d halted=%b req=%b err=%b pc=%h exp cnt=%0d halted=%b pc=%h",
               bus.instr_count, bus.halted, bus.imem_req, bus.err, bus.pc,
               m_cnt, hlt, m_pc);
    end
  endtask

  task automatic resume();
    bus.halt_req = 1'($urandom);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.halt_req = 1'b0;
    n_chk++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc ||
        bus.err !== 1'b0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL resume req=%b addr=%h err=%b halted=%b exp addr=%h",
               bus.imem_req, bus.imem_addr, bus.err, bus.halted, m_pc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 8'h00 || bus.ir !== 16'h0 ||
        bus.instr_count !== 16'h0 || bus.err !== 1'b0 || bus.busy !== 1'b0 ||
        bus.halted !== 1'b0 || bus.exec_en !== 1'b0 || bus.wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset req=%b pc=%h ir=%h cnt=%h err=%b busy=%b halted=%b exp all 0",
               bus.imem_req, bus.pc, bus.ir, bus.instr_count, bus.err,
               bus.busy, bus.halted);
    end
    rst = 1'b0;
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold busy=%b req=%b exp 0 0", bus.busy, bus.imem_req);
    end
  endtask

  task automatic test_basic();
    mem[0] = 16'h1000;
    mem[1] = 16'h2001;
    mem[2] = 16'h3002;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL start req=%b addr=%h exp 1 00", bus.imem_req, bus.imem_addr);
    end
    for (int i = 0; i < 3; i++) run_instr(0, 0);
    n_chk++;
    if (bus.ir !== 16'h3002 || bus.pc !== 8'd3 || bus.instr_count !== 16'd3) begin
      n_fail++;
      $display("FAIL basic ir=%h pc=%h cnt=%0d exp 3002 03 3",
               bus.ir, bus.pc, bus.instr_count);
    end
  endtask

  task automatic test_delay_halt();
    run_instr(0, 0);
    run_instr(0, 0);
    run_instr(3, 0);
    run_instr(0, 1);
    run_instr(0, 3);
    n_chk++;
    if (bus.halted !== 1'b1 || bus.pc !== 8'h08) begin
      n_fail++;
      $display("FAIL halt halted=%b pc=%h exp 1 08", bus.halted, bus.pc);
    end
    resume();
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 15; k++) begin
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.halted !== 1'b0 || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait k=%0d req=%b halted=%b err=%b exp 1 0 0",
                 k, bus.imem_req, bus.halted, bus.err);
      end
      @(negedge clk);
    end
    n_chk++;
    if (bus.halted !== 1'b1 || bus.err !== 1'b1 || bus.pc !== m_pc) begin
      n_fail++;
      $display("FAIL timeout halted=%b err=%b pc=%h exp 1 1 %h",
               bus.halted, bus.err, bus.pc, m_pc);
    end
    resume();
    run_instr(14, 0);
  endtask

  task automatic test_random_wrap();
    logic was_ff;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      int r;
      r = $urandom_range(0, 15);
      was_ff = (m_pc == 8'hFF);
      run_instr($urandom_range(0, 3), (r < 5) ? r : 0);
      if (was_ff) begin
        done = 1'b1;
        n_chk++;
        if (bus.pc !== 8'h00 || (!bus.halted && bus.imem_addr !== 8'h00)) begin
          n_fail++;
          $display("FAIL wrap pc=%h addr=%h exp 00", bus.pc, bus.imem_addr);
        end
      end
      if (bus.halted) resume();
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL wrap_reached pc=%h exp wrap past ff", bus.pc);
    end
  endtask

  task automatic test_rst_exec();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem[m_pc];
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.exec_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst ex=%b exp 1", bus.exec_en);
    end
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'hBEEF;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.pc !== 8'h00 ||
        bus.ir !== 16'h0 || bus.instr_count !== 16'h0 || bus.wb_en !== 1'b0 ||
        bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_exec busy=%b pc=%h ir=%h cnt=%0d wb=%b req=%b exp all 0",
               bus.busy, bus.pc, bus.ir, bus.instr_count, bus.wb_en,
               bus.imem_req);
    end
    @(negedge clk);
    bus.imem_ack = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.pc !== 8'h00 || bus.ir !== 16'h0) begin
      n_fail++;
      $display("FAIL late_ack busy=%b pc=%h ir=%h exp 0 00 0000",
               bus.busy, bus.pc, bus.ir);
    end
    m_pc = '0;
    m_ir = '0;
    m_cnt = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_instr(1, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_delay_halt();
    test_timeout();
    test_random_wrap();
    test_rst_exec();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
